// File: rtl/icache_tag_ctrl_nway.sv
// icache_tag_ctrl_nway: N-way icache tag lookup/fill controller in front of a single-port tag SRAM.
// Post-reset tag sweep, invalid-first/tree-PLRU victim, write buffer with read bypass, MSHR conflict check.
//
// state   | meaning
// ST_INIT | clearing every set to invalid, one set per cycle
// ST_RUN  | accepting lookups; a pending write-buffer entry blocks acceptance
module icache_tag_ctrl_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 64,
  parameter int TAG_W  = 20,
  parameter int MSHR_N = 8,
  parameter int TXN_W  = 4,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WAY_W  = $clog2(WAYS),
  localparam int MI_W   = $clog2(MSHR_N),
  localparam int ENT_W  = TAG_W + 1,
  localparam int LINE_W = WAYS * ENT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_vld,
  output logic                      req_rdy,
  input  logic [IDX_W-1:0]          req_index,
  input  logic [TAG_W-1:0]          req_tag,
  input  logic [1:0]                req_opcode,
  input  logic [TXN_W-1:0]          req_txnid,
  input  logic                      stall,
  output logic                      tag_ram_en,
  output logic                      tag_ram_wr_en,
  output logic [IDX_W-1:0]          tag_ram_addr,
  output logic [LINE_W-1:0]         tag_ram_din,
  input  logic [LINE_W-1:0]         tag_ram_dout,
  output logic                      rsp_vld,
  output logic                      rsp_hit,
  output logic [WAYS-1:0]           rsp_hit_way,
  output logic [WAY_W-1:0]          rsp_dest_way,
  output logic [IDX_W-1:0]          rsp_index,
  output logic [TAG_W-1:0]          rsp_tag,
  output logic [1:0]                rsp_opcode,
  output logic [TXN_W-1:0]          rsp_txnid,
  output logic                      rsp_conflict,
  input  logic [MSHR_N-1:0]         mshr_vld,
  input  logic [MSHR_N*IDX_W-1:0]   mshr_index,
  input  logic [MSHR_N*WAY_W-1:0]   mshr_way,
  input  logic                      mshr_release_vld,
  input  logic [MI_W-1:0]           mshr_release_idx,
  output logic                      busy_init
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic                s1_vld;
  logic [IDX_W-1:0]    s1_index;
  logic [TAG_W-1:0]    s1_tag;
  logic [1:0]          s1_opcode;
  logic [TXN_W-1:0]    s1_txnid;
  logic                wb_vld;
  logic [IDX_W-1:0]    wb_index;
  logic [LINE_W-1:0]   wb_data;
  logic [WAYS-2:0]     plru [SETS];

  logic                accept;
  logic                rsp_on;
  logic                fill_op;
  logic                snoop_op;
  logic [LINE_W-1:0]   line;
  logic                hit;
  logic [WAY_W-1:0]    hit_idx;
  logic [WAYS-1:0]     hit_oh;
  logic                inv_found;
  logic [WAY_W-1:0]    inv_idx;
  logic [WAYS-2:0]     cur;
  logic [WAYS-2:0]     plru_nxt;
  logic [WAY_W-1:0]    plru_vict;
  logic [WAY_W-1:0]    dest;
  logic                dir;
  int                  node;
  logic [LINE_W-1:0]   wb_new;
  logic                wb_load;
  logic                conf;

  assign req_rdy   = !rst && state == ST_RUN && !wb_vld && !stall;
  assign accept    = req_vld && req_rdy;
  assign busy_init = !rst && state == ST_INIT;
  assign rsp_on    = s1_vld && !rst;
  assign fill_op   = !s1_opcode[1];
  assign snoop_op  = s1_opcode == 2'b10;

  // Write-buffer drain and sweep writes both take the port ahead of any read.
  always_comb begin
    tag_ram_en    = 1'b0;
    tag_ram_wr_en = 1'b0;
    tag_ram_addr  = '0;
    tag_ram_din   = '0;
    if (!rst) begin
      if (state == ST_INIT) begin
        tag_ram_en    = 1'b1;
        tag_ram_wr_en = 1'b1;
        tag_ram_addr  = ptr;
      end else if (wb_vld) begin
        tag_ram_en    = 1'b1;
        tag_ram_wr_en = 1'b1;
        tag_ram_addr  = wb_index;
        tag_ram_din   = wb_data;
      end else if (accept) begin
        tag_ram_en    = 1'b1;
        tag_ram_addr  = req_index;
      end
    end
  end

  always_comb begin
    line      = (wb_vld && wb_index == s1_index) ? wb_data : tag_ram_dout;
    hit       = 1'b0;
    hit_idx   = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (line[w*ENT_W+TAG_W] && line[w*ENT_W +: TAG_W] == s1_tag) begin
        hit     = 1'b1;
        hit_idx = WAY_W'(w);
      end
      if (!line[w*ENT_W+TAG_W]) begin
        inv_found = 1'b1;
        inv_idx   = WAY_W'(w);
      end
    end
    hit_oh = '0;
    if (hit) hit_oh[hit_idx] = 1'b1;

    // Heap-ordered tree: node n has children 2n/2n+1, bit=1 steers the victim right.
    cur  = plru[s1_index];
    node = 1;
    for (int l = 0; l < WAY_W; l++) node = 2 * node + (cur[node-1] ? 1 : 0);
    plru_vict = WAY_W'(node - WAYS);
    dest      = hit ? hit_idx : (inv_found ? inv_idx : plru_vict);

    plru_nxt = cur;
    node     = 1;
    dir      = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      dir              = dest[WAY_W-1-l];
      plru_nxt[node-1] = !dir;
      node             = 2 * node + (dir ? 1 : 0);
    end

    wb_new  = line;
    wb_load = 1'b0;
    if (s1_vld && fill_op && !hit) begin
      wb_new[int'(dest)*ENT_W +: ENT_W] = {1'b1, s1_tag};
      wb_load = 1'b1;
    end else if (s1_vld && snoop_op && hit) begin
      wb_new[int'(dest)*ENT_W+TAG_W] = 1'b0;
      wb_load = 1'b1;
    end

    conf = 1'b0;
    for (int i = 0; i < MSHR_N; i++) begin
      if (mshr_vld[i] && mshr_index[i*IDX_W +: IDX_W] == s1_index &&
          mshr_way[i*WAY_W +: WAY_W] == dest &&
          !(mshr_release_vld && mshr_release_idx == MI_W'(i)))
        conf = 1'b1;
    end
  end

  assign rsp_vld      = rsp_on;
  assign rsp_hit      = rsp_on && hit;
  assign rsp_hit_way  = rsp_on ? hit_oh : '0;
  assign rsp_dest_way = rsp_on ? dest : '0;
  assign rsp_index    = rsp_on ? s1_index : '0;
  assign rsp_tag      = rsp_on ? s1_tag : '0;
  assign rsp_opcode   = rsp_on ? s1_opcode : '0;
  assign rsp_txnid    = rsp_on ? s1_txnid : '0;
  assign rsp_conflict = rsp_on && fill_op && conf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      ptr       <= '0;
      s1_vld    <= 1'b0;
      s1_index  <= '0;
      s1_tag    <= '0;
      s1_opcode <= '0;
      s1_txnid  <= '0;
      wb_vld    <= 1'b0;
      wb_index  <= '0;
      wb_data   <= '0;
      for (int s = 0; s < SETS; s++) plru[s] <= '0;
    end else begin
      if (state == ST_INIT) begin
        ptr <= ptr + 1'b1;
        if (ptr == IDX_W'(SETS - 1)) state <= ST_RUN;
      end
      s1_vld <= accept;
      if (accept) begin
        s1_index  <= req_index;
        s1_tag    <= req_tag;
        s1_opcode <= req_opcode;
        s1_txnid  <= req_txnid;
      end
      wb_vld <= wb_load;
      if (wb_load) begin
        wb_index <= s1_index;
        wb_data  <= wb_new;
      end
      if (s1_vld && fill_op) plru[s1_index] <= plru_nxt;
    end
  end

endmodule

// File: tb/tb_icache_tag_ctrl_nway.sv
// Bench for icache_tag_ctrl_nway: behavioural tag SRAM plus a set/way reference model
// using per-way touch timestamps for the PLRU victim; directed scenarios then random traffic.
module tb_icache_tag_ctrl_nway;
  localparam int WAYS = 4, SETS = 64, TAG_W = 20, MSHR_N = 8, TXN_W = 4;
  localparam int IDX_W = $clog2(SETS), WAY_W = $clog2(WAYS), MI_W = $clog2(MSHR_N);
  localparam int ENT_W = TAG_W + 1, LINE_W = WAYS * ENT_W;

  logic clk = 1'b0, rst = 1'b1;
  logic req_vld = 1'b0, req_rdy, stall = 1'b0;
  logic [IDX_W-1:0] req_index = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [1:0] req_opcode = '0;
  logic [TXN_W-1:0] req_txnid = '0;
  logic tag_ram_en, tag_ram_wr_en;
  logic [IDX_W-1:0] tag_ram_addr;
  logic [LINE_W-1:0] tag_ram_din, tag_ram_dout;
  logic rsp_vld, rsp_hit, rsp_conflict, busy_init;
  logic [WAYS-1:0] rsp_hit_way;
  logic [WAY_W-1:0] rsp_dest_way;
  logic [IDX_W-1:0] rsp_index;
  logic [TAG_W-1:0] rsp_tag;
  logic [1:0] rsp_opcode;
  logic [TXN_W-1:0] rsp_txnid;
  logic [MSHR_N-1:0] mshr_vld = '0;
  logic [MSHR_N*IDX_W-1:0] mshr_index = '0;
  logic [MSHR_N*WAY_W-1:0] mshr_way = '0;
  logic mshr_release_vld = 1'b0;
  logic [MI_W-1:0] mshr_release_idx = '0;

  icache_tag_ctrl_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .MSHR_N(MSHR_N), .TXN_W(TXN_W)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_index(req_index),
    .req_tag(req_tag), .req_opcode(req_opcode), .req_txnid(req_txnid), .stall(stall),
    .tag_ram_en(tag_ram_en), .tag_ram_wr_en(tag_ram_wr_en), .tag_ram_addr(tag_ram_addr),
    .tag_ram_din(tag_ram_din), .tag_ram_dout(tag_ram_dout), .rsp_vld(rsp_vld), .rsp_hit(rsp_hit),
    .rsp_hit_way(rsp_hit_way), .rsp_dest_way(rsp_dest_way), .rsp_index(rsp_index), .rsp_tag(rsp_tag),
    .rsp_opcode(rsp_opcode), .rsp_txnid(rsp_txnid), .rsp_conflict(rsp_conflict), .mshr_vld(mshr_vld),
    .mshr_index(mshr_index), .mshr_way(mshr_way), .mshr_release_vld(mshr_release_vld),
    .mshr_release_idx(mshr_release_idx), .busy_init(busy_init));

  always #5 clk = ~clk;

  // single-port tag SRAM, read data one cycle after the read
  logic [LINE_W-1:0] mem [SETS];
  always @(posedge clk) begin
    if (tag_ram_en) begin
      if (tag_ram_wr_en) mem[tag_ram_addr] <= tag_ram_din;
      else tag_ram_dout <= mem[tag_ram_addr];
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // reference contents and touch history
  bit ref_v [SETS][WAYS];
  logic [TAG_W-1:0] ref_t [SETS][WAYS];
  int stamp [SETS][WAYS];
  int tnow = 0;

  logic p_vld = 1'b0, p_hit, p_wr;
  logic [WAYS-1:0] p_oh;
  logic [WAY_W-1:0] p_dest;
  logic [IDX_W-1:0] p_idx;
  logic [TAG_W-1:0] p_tag;
  logic [1:0] p_op;
  logic [TXN_W-1:0] p_txn;
  logic [LINE_W-1:0] p_line;
  logic wb_next_g = 1'b0;
  logic [IDX_W-1:0] wb_idx_g;
  logic [LINE_W-1:0] wb_line_g;
  logic acc;
  logic [TXN_W-1:0] txn_ctr = '0;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        ref_v[s][w] = 0; ref_t[s][w] = '0; stamp[s][w] = 0;
      end
    tnow = 0; p_vld = 0; wb_next_g = 0;
  endtask

  // Tree-PLRU: at each split avoid the half holding the most recently touched way.
  function automatic int plru_vict(input int s);
    int lo, n, half, best, bs;
    lo = 0; n = WAYS;
    while (n > 1) begin
      half = n / 2; best = -1; bs = 0;
      for (int w = lo; w < lo + n; w++)
        if (stamp[s][w] > bs) begin bs = stamp[s][w]; best = w; end
      if (best >= 0 && best < lo + half) lo = lo + half;
      n = half;
    end
    return lo;
  endfunction

  task automatic model_accept(input int idx, input logic [TAG_W-1:0] tg, input logic [1:0] op, input logic [TXN_W-1:0] tx);
    int h, v, d;
    h = -1; v = -1;
    for (int w = 0; w < WAYS; w++) if (h < 0 && ref_v[idx][w] && ref_t[idx][w] == tg) h = w;
    for (int w = 0; w < WAYS; w++) if (v < 0 && !ref_v[idx][w]) v = w;
    if (v < 0) v = plru_vict(idx);
    d = (h >= 0) ? h : v;
    p_wr = 0;
    if (op < 2) begin
      tnow++; stamp[idx][d] = tnow;
      if (h < 0) begin ref_v[idx][d] = 1; ref_t[idx][d] = tg; p_wr = 1; end
    end else if (op == 2 && h >= 0) begin
      ref_v[idx][d] = 0; p_wr = 1;
    end
    p_hit = (h >= 0);
    p_oh = '0;
    if (h >= 0) p_oh[h] = 1'b1;
    p_dest = WAY_W'(d); p_idx = IDX_W'(idx); p_tag = tg; p_op = op; p_txn = tx;
    for (int w = 0; w < WAYS; w++) p_line[w*ENT_W +: ENT_W] = {ref_v[idx][w], ref_t[idx][w]};
  endtask

  function automatic logic exp_conf();
    logic c = 1'b0;
    if (p_op >= 2) return 1'b0;
    for (int i = 0; i < MSHR_N; i++)
      if (mshr_vld[i] && mshr_index[i*IDX_W +: IDX_W] == p_idx && mshr_way[i*WAY_W +: WAY_W] == p_dest &&
          !(mshr_release_vld && int'(mshr_release_idx) == i)) c = 1'b1;
    return c;
  endfunction

  task automatic cycle(input logic v, input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tg,
                       input logic [1:0] op, input logic [TXN_W-1:0] tx, input logic st);
    logic wb_cur;
    @(posedge clk); #1;
    req_vld = v; req_index = idx; req_tag = tg; req_opcode = op; req_txnid = tx; stall = st;
    @(negedge clk);
    wb_cur = wb_next_g; wb_next_g = 0;
    check("req_rdy", req_rdy, !st && !wb_cur);
    check("busy_run", busy_init, 0);
    if (wb_cur) begin
      check("wb_write", {tag_ram_en, tag_ram_wr_en, tag_ram_addr}, {2'b11, wb_idx_g});
      check("wb_data", tag_ram_din, wb_line_g);
    end else check("no_write", tag_ram_wr_en, 0);
    if (p_vld) begin
      check("rsp_vld", rsp_vld, 1);
      check("rsp_hit", rsp_hit, p_hit);
      check("rsp_hit_way", rsp_hit_way, p_oh);
      check("rsp_dest_way", rsp_dest_way, p_dest);
      check("rsp_echo", {rsp_index, rsp_tag, rsp_opcode, rsp_txnid}, {p_idx, p_tag, p_op, p_txn});
      check("rsp_conflict", rsp_conflict, exp_conf());
      if (p_wr) begin wb_next_g = 1; wb_idx_g = p_idx; wb_line_g = p_line; end
      p_vld = 0;
    end else check("rsp_idle", rsp_vld, 0);
    acc = req_vld && req_rdy;
    if (acc) begin
      check("rd_issue", {tag_ram_en, tag_ram_wr_en, tag_ram_addr}, {2'b10, idx});
      model_accept(int'(idx), tg, op, tx);
      p_vld = 1;
    end
  endtask

  task automatic issue(input int idx, input logic [TAG_W-1:0] tg, input logic [1:0] op);
    int n = 0;
    do begin cycle(1'b1, IDX_W'(idx), tg, op, txn_ctr, 1'b0); n++; end while (!acc && n < 20);
    if (!acc) check("accept_timeout", 0, 1);
    txn_ctr++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, '0, 2'b00, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1; req_vld = 0; stall = 0;
    repeat (n) begin
      @(negedge clk);
      check("rst_outputs", {busy_init, req_rdy, rsp_vld, rsp_hit, tag_ram_en, tag_ram_wr_en}, 0);
      @(posedge clk); #1;
    end
    rst = 0;
    for (int k = 0; k < SETS; k++) begin
      @(negedge clk);
      check("sweep", {busy_init, req_rdy, tag_ram_en, tag_ram_wr_en, tag_ram_addr}, {4'b1011, IDX_W'(k)});
      check("sweep_din", tag_ram_din, 0);
    end
    @(negedge clk);
    check("init_done", {busy_init, req_rdy}, 2'b01);
    model_reset();
  endtask

  localparam logic [1:0] OP_F = 2'b00, OP_P = 2'b01, OP_S = 2'b10;
  logic [TAG_W-1:0] tags [6] = '{20'h00123, 20'h00200, 20'h00201, 20'hABCDE, 20'h00300, 20'h7F00F};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    // empty set miss then hit
    issue(5, 20'h123, OP_F); idle(3);
    issue(5, 20'h123, OP_F); idle(2);
    // fill ways 1..3 then touch 0,2,1 so way 3 is the PLRU victim
    issue(5, 20'h200, OP_F); idle(2);
    issue(5, 20'h201, OP_F); idle(2);
    issue(5, 20'h202, OP_P); idle(2);
    issue(5, 20'h123, OP_F); idle(1);
    issue(5, 20'h201, OP_F); idle(1);
    issue(5, 20'h200, OP_F); idle(1);
    issue(5, 20'h300, OP_F); idle(3);
    issue(5, 20'h300, OP_F); idle(1);
    issue(5, 20'h301, OP_F); idle(3);
    // back-to-back same set relies on write-buffer bypass
    issue(9, 20'h00A, OP_F);
    issue(9, 20'h00A, OP_F); idle(3);
    // snoop invalidate followed immediately by a fetch of the same tag
    issue(5, 20'h201, OP_S);
    issue(5, 20'h201, OP_F); idle(3);
    // MSHR conflict, then same entry releasing
    mshr_vld = 8'b0000_1000;
    mshr_index[3*IDX_W +: IDX_W] = IDX_W'(5);
    mshr_way[3*WAY_W +: WAY_W] = WAY_W'(1);
    issue(5, 20'h200, OP_F); idle(2);
    mshr_release_vld = 1; mshr_release_idx = MI_W'(3);
    issue(5, 20'h200, OP_F); idle(2);
    mshr_vld = '0; mshr_release_vld = 0;
    // reset lands on the write-buffer drain cycle
    issue(5, 20'h400, OP_F);
    cycle(1'b0, '0, '0, 2'b00, '0, 1'b0);
    do_reset(2);
    issue(5, 20'h123, OP_F); idle(2);

    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset(1);
      mshr_vld = MSHR_N'($urandom);
      for (int j = 0; j < MSHR_N; j++) begin
        mshr_index[j*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, 3));
        mshr_way[j*WAY_W +: WAY_W] = WAY_W'($urandom_range(0, WAYS - 1));
      end
      mshr_release_vld = 1'($urandom_range(0, 1));
      mshr_release_idx = MI_W'($urandom_range(0, MSHR_N - 1));
      cycle($urandom_range(0, 3) != 0, IDX_W'($urandom_range(0, 3)), tags[$urandom_range(0, 5)],
            2'($urandom_range(0, 3)), TXN_W'($urandom), $urandom_range(0, 4) == 0);
    end
    mshr_vld = '0;
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
